// File: rtl/vic_pot_digitizer.sv
// VIC 656x POTX/POTY RC-timing digitizer: periodic discharge/charge cycle with
// a comparator trip capture per channel, published to POTX/POTY on each update.
module vic_pot_digitizer #(
    parameter int unsigned DISCHARGE_CYCLES = 256,
    parameter int unsigned CHARGE_CYCLES    = 256,
    parameter int unsigned OFFSET           = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] pd_in,       // [7:0] = X, [15:8] = Y
    input  logic [1:0]  pd_conn,
    output logic [7:0]  potx,
    output logic [7:0]  poty,
    output logic        pot_strobe,
    output logic        pot_discharge,
    output logic [1:0]  pot_line
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] DIS_LAST = CNT_W'(DISCHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHG_LAST = CNT_W'(CHARGE_CYCLES - 1);
    localparam logic [CNT_W:0]   OFF_W    = (CNT_W+1)'(OFFSET);

    typedef enum logic [1:0] {
        S_DISCHARGE = 2'd0,
        S_CHARGE    = 2'd1,
        S_UPDATE    = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [1:0][CNT_W-1:0]      thr_q, thr_d;
    logic [1:0]                 thr_en_q, thr_en_d;
    logic [1:0]                 tripped_q, tripped_d;
    logic [1:0][CNT_W-1:0]      cap_q, cap_d;
    logic [CNT_W-1:0]           potx_q, potx_d;
    logic [CNT_W-1:0]           poty_q, poty_d;
    logic                       strobe_q, strobe_d;
    logic                       dis_q, dis_d;

    // Trip threshold: position plus comparator delay, saturating at 255.
    function automatic logic [CNT_W-1:0] sat_thr(input logic [CNT_W-1:0] pd);
        logic [CNT_W:0] sum;
        sum = {1'b0, pd} + OFF_W;
        return (sum > (CNT_W+1)'(255)) ? 8'hFF : sum[CNT_W-1:0];
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_DISCHARGE;
        else          state_q <= state_d;
    end

    // Next-state and datapath logic; all timing advances only on ce except UPDATE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        thr_d     = thr_q;
        thr_en_d  = thr_en_q;
        tripped_d = tripped_q;
        cap_d     = cap_q;
        potx_d    = potx_q;
        poty_d    = poty_q;
        strobe_d  = 1'b0;

        case (state_q)
            S_DISCHARGE: begin
                if (ce) begin
                    if (cnt_q == DIS_LAST) begin
                        state_d   = S_CHARGE;
                        cnt_d     = '0;
                        thr_d[0]  = sat_thr(pd_in[7:0]);
                        thr_d[1]  = sat_thr(pd_in[15:8]);
                        thr_en_d  = pd_conn;
                        tripped_d = 2'b00;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_CHARGE: begin
                if (ce) begin
                    for (int i = 0; i < 2; i++) begin
                        if (thr_en_q[i] && !tripped_q[i] && (cnt_q == thr_q[i])) begin
                            tripped_d[i] = 1'b1;
                            cap_d[i]     = cnt_q;
                        end
                    end
                    if (cnt_q == CHG_LAST) begin
                        state_d = S_UPDATE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_UPDATE: begin
                potx_d    = tripped_q[0] ? cap_q[0] : 8'hFF;
                poty_d    = tripped_q[1] ? cap_q[1] : 8'hFF;
                strobe_d  = 1'b1;
                cnt_d     = '0;
                tripped_d = 2'b00;
                state_d   = S_DISCHARGE;
            end
            default: begin
                state_d = S_DISCHARGE;
                cnt_d   = '0;
            end
        endcase

        dis_d = (state_d == S_DISCHARGE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            thr_q     <= {8'hFF, 8'hFF};
            thr_en_q  <= 2'b00;
            tripped_q <= 2'b00;
            cap_q     <= '0;
            potx_q    <= 8'hFF;
            poty_q    <= 8'hFF;
            strobe_q  <= 1'b0;
            dis_q     <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            thr_q     <= thr_d;
            thr_en_q  <= thr_en_d;
            tripped_q <= tripped_d;
            cap_q     <= cap_d;
            potx_q    <= potx_d;
            poty_q    <= poty_d;
            strobe_q  <= strobe_d;
            dis_q     <= dis_d;
        end
    end

    assign potx          = potx_q;
    assign poty          = poty_q;
    assign pot_strobe    = strobe_q;
    assign pot_discharge = dis_q;
    assign pot_line      = tripped_q;

endmodule

// File: tb/tb_vic_pot_digitizer.sv
// Self-checking bench for vic_pot_digitizer: default instance plus a short,
// offset instance, checked against a plain arithmetic model of the A/D rules.
module tb_vic_pot_digitizer;

    localparam int unsigned O_DIS = 16;
    localparam int unsigned O_CHG = 64;
    localparam int unsigned O_OFF = 8;
    localparam int          PERIOD = 256 + 256 + 1;

    logic        clk;
    logic        reset_n;
    logic        ce;
    logic [15:0] pd_in, pd_in2;
    logic [1:0]  pd_conn, pd_conn2;
    logic [7:0]  potx, poty, potx2, poty2;
    logic        pot_strobe, pot_strobe2;
    logic        pot_discharge, pot_discharge2;
    logic [1:0]  pot_line, pot_line2;

    int checks   = 0;
    int failures = 0;
    int ce_div   = 1;
    int ce_ph    = 0;
    logic ce_seen;

    vic_pot_digitizer dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .pd_in(pd_in), .pd_conn(pd_conn),
        .potx(potx), .poty(poty), .pot_strobe(pot_strobe),
        .pot_discharge(pot_discharge), .pot_line(pot_line)
    );

    vic_pot_digitizer #(.DISCHARGE_CYCLES(O_DIS), .CHARGE_CYCLES(O_CHG), .OFFSET(O_OFF)) dut_o (
        .clk(clk), .reset_n(reset_n), .ce(ce), .pd_in(pd_in2), .pd_conn(pd_conn2),
        .potx(potx2), .poty(poty2), .pot_strobe(pot_strobe2),
        .pot_discharge(pot_discharge2), .pot_line(pot_line2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ce generator: one tick every ce_div clocks, changed away from the active edge.
    initial begin
        ce = 1'b1;
        forever begin
            @(negedge clk);
            ce_ph = (ce_ph + 1) % ce_div;
            ce    = (ce_ph == 0);
        end
    end

    // Reference: value a channel reports given the inputs seen at the latch.
    function automatic logic [7:0] exp_pot(input logic [7:0] pd, input logic conn,
                                           input int off, input int chg);
        int t;
        if (!conn) return 8'hFF;
        t = int'(pd) + off;
        if (t > 255) t = 255;
        if (t >= chg) return 8'hFF;
        return 8'(t);
    endfunction

    task automatic step();
        @(posedge clk);
        ce_seen = ce;
        #1;
    endtask

    task automatic wait_strobe(input bit which, input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < limit) begin
            step();
            n++;
            if ((which ? pot_strobe2 : pot_strobe) === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        pd_in    = {8'd200, 8'd40};
        pd_conn  = 2'b11;
        pd_in2   = 16'h0000;
        pd_conn2 = 2'b00;
        repeat (3) step();
        checks++; if (potx !== 8'hFF) begin failures++; $display("FAIL reset_potx got=%h exp=ff", potx); end
        checks++; if (poty !== 8'hFF) begin failures++; $display("FAIL reset_poty got=%h exp=ff", poty); end
        checks++; if (pot_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", pot_strobe); end
        checks++; if (pot_discharge !== 1'b1) begin failures++; $display("FAIL reset_discharge got=%b exp=1", pot_discharge); end
        checks++; if (pot_line !== 2'b00) begin failures++; $display("FAIL reset_line got=%b exp=00", pot_line); end
        checks++; if (potx2 !== 8'hFF) begin failures++; $display("FAIL reset_potx2 got=%h exp=ff", potx2); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_first_strobe();
        int n; bit ok;
        wait_strobe(1'b0, PERIOD + 50, n, ok);
        checks++; if (!ok || n != PERIOD) begin failures++; $display("FAIL first_strobe_latency got=%0d ok=%0b exp=%0d", n, ok, PERIOD); end
        checks++; if (potx !== 8'd40) begin failures++; $display("FAIL first_potx got=%0d exp=40", potx); end
        checks++; if (poty !== 8'd200) begin failures++; $display("FAIL first_poty got=%0d exp=200", poty); end
    endtask

    task automatic test_unconnected();
        int n; bit ok;
        pd_in   = {8'd10, 8'd123};
        pd_conn = 2'b01;
        wait_strobe(1'b0, PERIOD + 50, n, ok);
        checks++; if (!ok || n != PERIOD) begin failures++; $display("FAIL unconn_period got=%0d ok=%0b exp=%0d", n, ok, PERIOD); end
        checks++; if (potx !== 8'd123) begin failures++; $display("FAIL unconn_potx got=%0d exp=123", potx); end
        checks++; if (poty !== 8'hFF) begin failures++; $display("FAIL unconn_poty got=%h exp=ff", poty); end
    endtask

    task automatic test_random();
        int n; bit ok;
        logic [7:0] x, y, ex, ey;
        logic [1:0] c;
        for (int it = 0; it < 6; it++) begin
            case ($urandom_range(0, 3))
                0: x = 8'd0;
                1: x = 8'd255;
                default: x = 8'($urandom);
            endcase
            y = 8'($urandom);
            c = 2'($urandom);
            pd_in   = {y, x};
            pd_conn = c;
            ex = exp_pot(x, c[0], 0, 256);
            ey = exp_pot(y, c[1], 0, 256);
            wait_strobe(1'b0, PERIOD + 50, n, ok);
            checks++; if (!ok || n != PERIOD) begin failures++; $display("FAIL rand_period it=%0d got=%0d exp=%0d", it, n, PERIOD); end
            checks++; if (potx !== ex) begin failures++; $display("FAIL rand_potx it=%0d got=%h exp=%h", it, potx, ex); end
            checks++; if (poty !== ey) begin failures++; $display("FAIL rand_poty it=%0d got=%h exp=%h", it, poty, ey); end
        end
    endtask

    task automatic test_offset();
        int n; bit ok;
        logic [7:0] vals [4];
        logic [7:0] y, ex, ey;
        vals[0] = 8'd250; vals[1] = 8'd0; vals[2] = 8'd100; vals[3] = 8'd55;
        wait_strobe(1'b1, 200, n, ok);
        checks++; if (!ok) begin failures++; $display("FAIL offset_sync got=timeout exp=strobe"); end
        for (int k = 0; k < 4; k++) begin
            y = 8'($urandom_range(0, 70));
            pd_in2   = {y, vals[k]};
            pd_conn2 = 2'b11;
            ex = exp_pot(vals[k], 1'b1, O_OFF, O_CHG);
            ey = exp_pot(y, 1'b1, O_OFF, O_CHG);
            wait_strobe(1'b1, 200, n, ok);
            checks++; if (!ok || n != O_DIS + O_CHG + 1) begin failures++; $display("FAIL offset_period k=%0d got=%0d exp=%0d", k, n, O_DIS + O_CHG + 1); end
            checks++; if (potx2 !== ex) begin failures++; $display("FAIL offset_potx k=%0d got=%h exp=%h", k, potx2, ex); end
            checks++; if (poty2 !== ey) begin failures++; $display("FAIL offset_poty k=%0d got=%h exp=%h", k, poty2, ey); end
        end
    endtask

    task automatic test_mid_change();
        int n; bit ok;
        logic [7:0] prev;
        wait_strobe(1'b0, PERIOD + 50, n, ok);
        prev    = potx;
        pd_in   = {8'd20, 8'd100};
        pd_conn = 2'b11;
        repeat (256 + 50) step();
        checks++; if (pot_discharge !== 1'b0) begin failures++; $display("FAIL mid_discharge got=%b exp=0", pot_discharge); end
        checks++; if (potx !== prev) begin failures++; $display("FAIL mid_hold got=%h exp=%h", potx, prev); end
        pd_in = {8'd20, 8'd30};
        wait_strobe(1'b0, PERIOD, n, ok);
        checks++; if (!ok || n != PERIOD - 306) begin failures++; $display("FAIL mid_latency got=%0d exp=%0d", n, PERIOD - 306); end
        checks++; if (potx !== 8'd100) begin failures++; $display("FAIL mid_potx_old got=%0d exp=100", potx); end
        wait_strobe(1'b0, PERIOD + 50, n, ok);
        checks++; if (!ok || potx !== 8'd30) begin failures++; $display("FAIL mid_potx_new got=%0d exp=30", potx); end
    endtask

    task automatic test_ce_quarter();
        int n; bit ok;
        int guard;
        ce_div = 4;
        wait_strobe(1'b0, 4 * PERIOD + 50, n, ok);
        pd_in   = {8'd90, 8'd0};
        pd_conn = 2'b11;
        guard = 0;
        while (pot_discharge === 1'b1 && guard < 4 * 300) begin step(); guard++; end
        checks++; if (pot_discharge !== 1'b0) begin failures++; $display("FAIL q_charge_entry got=timeout exp=charge"); end
        checks++; if (pot_line[0] !== 1'b0) begin failures++; $display("FAIL q_line_before got=%b exp=0", pot_line[0]); end
        guard = 0;
        do begin step(); guard++; end while (!ce_seen && guard < 8);
        checks++; if (pot_line[0] !== 1'b1) begin failures++; $display("FAIL q_line_first_ce got=%b exp=1", pot_line[0]); end
        wait_strobe(1'b0, 4 * PERIOD + 50, n, ok);
        checks++; if (!ok || potx !== 8'd0) begin failures++; $display("FAIL q_potx got=%h ok=%0b exp=00", potx, ok); end
        step();
        checks++; if (pot_strobe !== 1'b0) begin failures++; $display("FAIL q_strobe_width got=%b exp=0", pot_strobe); end
        checks++; if (pot_line !== 2'b00 || pot_discharge !== 1'b1) begin failures++; $display("FAIL q_discharge_clear got=%b/%b exp=00/1", pot_line, pot_discharge); end
        ce_div = 1;
    endtask

    task automatic test_reset_mid_charge();
        int n; bit ok;
        bit saw;
        wait_strobe(1'b0, 4 * PERIOD + 50, n, ok);
        pd_in   = {8'd5, 8'd77};
        pd_conn = 2'b11;
        wait_strobe(1'b0, PERIOD + 50, n, ok);
        repeat (256 + 128) step();
        checks++; if (pot_line[0] !== 1'b1 || pot_discharge !== 1'b0) begin failures++; $display("FAIL rst_pre_line got=%b/%b exp=1/0", pot_line[0], pot_discharge); end
        reset_n = 1'b0;
        #1;
        checks++; if (potx !== 8'hFF || poty !== 8'hFF) begin failures++; $display("FAIL rst_pot got=%h/%h exp=ff/ff", potx, poty); end
        checks++; if (pot_line !== 2'b00 || pot_discharge !== 1'b1) begin failures++; $display("FAIL rst_state got=%b/%b exp=00/1", pot_line, pot_discharge); end
        saw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (pot_strobe !== 1'b0) saw = 1'b1;
        end
        checks++; if (saw) begin failures++; $display("FAIL rst_no_strobe got=1 exp=0"); end
        @(negedge clk);
        reset_n = 1'b1;
        wait_strobe(1'b0, PERIOD + 50, n, ok);
        checks++; if (!ok || n != PERIOD) begin failures++; $display("FAIL rst_restart got=%0d exp=%0d", n, PERIOD); end
        checks++; if (potx !== 8'd77 || poty !== 8'd5) begin failures++; $display("FAIL rst_restart_pot got=%0d/%0d exp=77/5", potx, poty); end
    endtask

    initial begin
        test_reset();
        test_first_strobe();
        test_unconnected();
        test_random();
        test_offset();
        test_mid_change();
        test_ce_quarter();
        test_reset_mid_charge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
